gerenciador_alarme_temperatura: RTL and testbench
=================================================

# gerenciador_alarme_temperatura

Alarm annunciator stage directly downstream of the temperature control system. It consumes the raw `alarmeSonoroTemperatura` level and applies a persistence filter. It runs the operator alarm sequence (unacknowledged, acknowledged, return-to-normal) and drives the control-room siren and lamp. It escalates an unacknowledged over-temperature into a sticky SCRAM request.

## Interface
- `DEBOUNCE_CICLOS`, 4: consecutive identical raw samples required to trip or clear the filtered condition (≥1).
- `PERIODO_PISCA`, 8: half-period, in cycles, of the siren/lamp blink (≥1).
- `TIMEOUT_SCRAM`, 1000: cycles in the unacknowledged alarm state before the SCRAM request (≥1).
- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `alarmeSonoroTemperatura` input 1: raw over-temperature level from the temperature control system.
- `botaoReconhecer` input 1: operator acknowledge button, level; only the rising edge acts.
- `sirene` output 1: audible siren drive.
- `lampada` output 1: alarm lamp drive.
- `pedidoScram` output 1: sticky reactor-trip request.
- `estadoAlarme` output 2: current state encoding, for the supervision panel.

## Operation
- Filter:
  - A counter tracks consecutive raw samples that differ from the filtered condition.
  - When the count reaches `DEBOUNCE_CICLOS`, the filtered condition flips: a trip or clear event.
  - A sample equal to the filtered condition zeroes the counter.
- Acknowledge event: `botaoReconhecer`=1 while its registered previous value was 0.
- States: NORMAL=0, ALARME_NAO_RECONHECIDO=1, ALARME_RECONHECIDO=2, RETORNO_NAO_RECONHECIDO=3.
- Transitions:
  - NORMAL → ALARME_NAO_RECONHECIDO on trip.
  - ALARME_NAO_RECONHECIDO → ALARME_RECONHECIDO on acknowledge.
  - ALARME_NAO_RECONHECIDO → RETORNO_NAO_RECONHECIDO on clear without acknowledge.
  - ALARME_NAO_RECONHECIDO → NORMAL on acknowledge and clear in the same cycle.
  - ALARME_RECONHECIDO → NORMAL on clear.
  - RETORNO_NAO_RECONHECIDO → NORMAL on acknowledge.
  - RETORNO_NAO_RECONHECIDO → ALARME_NAO_RECONHECIDO on a new trip; a trip wins over a simultaneous acknowledge.
- Acknowledge is ignored in NORMAL and ALARME_RECONHECIDO.
- Blink phase:
  - Counter restarts at every entry into state 1 or 3.
  - Phase starts at 1 and toggles every `PERIODO_PISCA` cycles.
- Outputs by state:
  - `sirene` equals the blink phase in state 1; 0 in all other states.
  - `lampada` equals the blink phase in states 1 and 3; 1 in state 2; 0 in state 0.
- Timeout counter:
  - Counts cycles spent in state 1 and zeroes on leaving it.
  - On reaching `TIMEOUT_SCRAM`, `pedidoScram` sets.
  - `pedidoScram` clears only on `reset`.
- Counter widths: `$clog2(param+1)`, saturating, never wrapping.

## Timing
- All outputs are registered.
- Reset values: `sirene`=0, `lampada`=0, `pedidoScram`=0, `estadoAlarme`=0; all counters and the button history register are 0.
- Trip latency:
  - Raw input rising before edge k, held high, gives a trip on edge k+`DEBOUNCE_CICLOS`−1.
  - `estadoAlarme`=1 and `sirene`=`lampada`=1 are visible after that edge.
- Clear latency is symmetric.
- A raw glitch shorter than `DEBOUNCE_CICLOS` cycles has no effect.
- Acknowledge takes effect on the edge that samples the button rising; holding the button produces no further events.
- `pedidoScram` rises on the edge ending the `TIMEOUT_SCRAM`-th consecutive cycle in state 1. An acknowledge on that same edge still sets it.
- `reset` asserted mid-sequence returns every output to its reset value immediately, without waiting for a clock edge. After release, a still-high raw input re-trips after `DEBOUNCE_CICLOS` cycles.

## Configuration
- `ESCALONAMENTO_SCRAM_EN` defined: timeout counter and `pedidoScram` behave as specified above.
- `ESCALONAMENTO_SCRAM_EN` not defined: no timeout counter is instantiated and `pedidoScram` is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package `pkg_usina`:
  - State enum `estado_alarme_t` (2 bits, encodings above).
  - Default parameter constants.
- Sub-module `filtro_persistencia`: raw input, `DEBOUNCE_CICLOS` in; filtered level plus one-cycle trip and clear pulses out.
- The FSM, blink and timeout logic stay in the top module.

## Test plan
- Raw high for 3 cycles, then low (`DEBOUNCE_CICLOS`=4) → state stays 0; `sirene`=`lampada`=0 throughout.
- Raw held high → state 1 after the 4th high sample; `sirene` toggles 1/0 every 8 cycles. Acknowledge pulse → state 2, `sirene`=0, `lampada`=1. Raw low ≥4 cycles → state 0.
- Trip, then raw low before acknowledge → state 3, `lampada` blinking, `sirene`=0. Acknowledge → state 0. Separately, raw high again in state 3 → state 1.
- Acknowledge edge and clear event on the same edge in state 1 → state 0 directly.
- Trip with no acknowledge (`TIMEOUT_SCRAM`=20) → `pedidoScram`=1 after 20 cycles in state 1, still 1 after acknowledge and clear, 0 only after `reset`. Built without `ESCALONAMENTO_SCRAM_EN` → `pedidoScram` stays 0.
- `reset` pulse mid-alarm (between clock edges) → all outputs 0 immediately. After release, with raw held high, state 1 after 4 cycles.

Source files
------------

// File: rtl/gerenciador_alarme_temperatura_pkg.sv
// Shared definitions for the plant alarm annunciator: state encoding and
// default timing constants.
package pkg_usina;

  typedef enum logic [1:0] {
    NORMAL                   = 2'd0,
    ALARME_NAO_RECONHECIDO   = 2'd1,
    ALARME_RECONHECIDO       = 2'd2,
    RETORNO_NAO_RECONHECIDO  = 2'd3
  } estado_alarme_t;

  localparam int DEBOUNCE_CICLOS_PADRAO = 4;
  localparam int PERIODO_PISCA_PADRAO   = 8;
  localparam int TIMEOUT_SCRAM_PADRAO   = 1000;

endpackage

// File: rtl/gerenciador_alarme_temperatura_filtro.sv
// Persistence filter: the filtered level flips only after DEBOUNCE_CICLOS
// consecutive raw samples disagree with it; trip/clear pulse on that edge.
module filtro_persistencia
  import pkg_usina::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto,
  output logic nivelFiltrado,
  output logic pulsoDisparo,
  output logic pulsoLiberacao
);

  localparam int LARGURA = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(DEBOUNCE_CICLOS - 1);

  logic [LARGURA-1:0] contador;
  logic               nivel;
  logic               difere;
  logic               vira;

  assign difere = (bruto != nivel);
  // The flip is decided combinationally so the FSM reacts on the same edge.
  assign vira           = difere && (contador == LIMITE);
  assign pulsoDisparo   = vira && !nivel;
  assign pulsoLiberacao = vira && nivel;
  assign nivelFiltrado  = nivel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador <= '0;
      nivel    <= 1'b0;
    end else if (!difere) begin
      contador <= '0;
    end else if (vira) begin
      contador <= '0;
      nivel    <= bruto;
    end else if (contador != LIMITE) begin
      contador <= contador + LARGURA'(1);
    end
  end

endmodule

// File: rtl/gerenciador_alarme_temperatura.sv
// Temperature alarm annunciator: debounce, operator sequence, siren/lamp blink.
// Define ESCALONAMENTO_SCRAM_EN to enable the unacknowledged-alarm SCRAM timeout.
module gerenciador_alarme_temperatura
  import pkg_usina::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int PERIODO_PISCA   = PERIODO_PISCA_PADRAO,
  parameter int TIMEOUT_SCRAM   = TIMEOUT_SCRAM_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alarmeSonoroTemperatura,
  input  logic       botaoReconhecer,
  output logic       sirene,
  output logic       lampada,
  output logic       pedidoScram,
  output logic [1:0] estadoAlarme
);

  if (DEBOUNCE_CICLOS < 1 || PERIODO_PISCA < 1 || TIMEOUT_SCRAM < 1) begin : gParametroInvalido
    $error("gerenciador_alarme_temperatura: parameters must be >= 1");
  end

  localparam int LARG_PISCA = $clog2(PERIODO_PISCA + 1);
  localparam logic [LARG_PISCA-1:0] LIMITE_PISCA = LARG_PISCA'(PERIODO_PISCA - 1);

  logic           unusedNivelFiltrado;
  logic           disparo;
  logic           liberacao;
  logic           botaoAnterior;
  logic           reconhecer;
  estado_alarme_t estado;
  estado_alarme_t estadoNext;
  logic [LARG_PISCA-1:0] contPisca;
  logic [LARG_PISCA-1:0] contPiscaNext;
  logic           fase;
  logic           faseNext;
  logic           entrando;
  logic           piscaNext;

  filtro_persistencia #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) uFiltro (
    .clock          (clock),
    .reset          (reset),
    .bruto          (alarmeSonoroTemperatura),
    .nivelFiltrado  (unusedNivelFiltrado),
    .pulsoDisparo   (disparo),
    .pulsoLiberacao (liberacao)
  );

  assign reconhecer = botaoReconhecer && !botaoAnterior;

  always_comb begin
    estadoNext = estado;
    case (estado)
      NORMAL:
        if (disparo) estadoNext = ALARME_NAO_RECONHECIDO;
      ALARME_NAO_RECONHECIDO:
        if (reconhecer && liberacao) estadoNext = NORMAL;
        else if (reconhecer)         estadoNext = ALARME_RECONHECIDO;
        else if (liberacao)          estadoNext = RETORNO_NAO_RECONHECIDO;
      ALARME_RECONHECIDO:
        if (liberacao) estadoNext = NORMAL;
      RETORNO_NAO_RECONHECIDO:
        // A fresh trip outranks an acknowledge arriving on the same edge.
        if (disparo)         estadoNext = ALARME_NAO_RECONHECIDO;
        else if (reconhecer) estadoNext = NORMAL;
      default:
        estadoNext = NORMAL;
    endcase
  end

  always_comb begin
    piscaNext     = (estadoNext == ALARME_NAO_RECONHECIDO) ||
                    (estadoNext == RETORNO_NAO_RECONHECIDO);
    entrando      = piscaNext && (estadoNext != estado);
    contPiscaNext = '0;
    faseNext      = 1'b0;
    if (entrando) begin
      faseNext = 1'b1;
    end else if (piscaNext) begin
      if (contPisca == LIMITE_PISCA) begin
        faseNext = !fase;
      end else begin
        contPiscaNext = contPisca + LARG_PISCA'(1);
        faseNext      = fase;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= NORMAL;
      contPisca     <= '0;
      fase          <= 1'b0;
      botaoAnterior <= 1'b0;
      sirene        <= 1'b0;
      lampada       <= 1'b0;
    end else begin
      estado        <= estadoNext;
      contPisca     <= contPiscaNext;
      fase          <= faseNext;
      botaoAnterior <= botaoReconhecer;
      sirene        <= (estadoNext == ALARME_NAO_RECONHECIDO) && faseNext;
      lampada       <= (estadoNext == ALARME_RECONHECIDO) || (piscaNext && faseNext);
    end
  end

  assign estadoAlarme = estado;

`ifdef ESCALONAMENTO_SCRAM_EN
  localparam int LARG_TIMEOUT = $clog2(TIMEOUT_SCRAM + 1);
  localparam logic [LARG_TIMEOUT-1:0] LIMITE_TIMEOUT = LARG_TIMEOUT'(TIMEOUT_SCRAM - 1);
  localparam logic [LARG_TIMEOUT-1:0] MAX_TIMEOUT    = LARG_TIMEOUT'(TIMEOUT_SCRAM);

  logic [LARG_TIMEOUT-1:0] contTimeout;
  logic                    scram;

  // The cycle that leaves state 1 still counts, so an acknowledge on the
  // deadline edge cannot dodge the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contTimeout <= '0;
      scram       <= 1'b0;
    end else if (estado == ALARME_NAO_RECONHECIDO) begin
      if (contTimeout >= LIMITE_TIMEOUT) scram <= 1'b1;
      if (estadoNext != ALARME_NAO_RECONHECIDO) contTimeout <= '0;
      else if (contTimeout != MAX_TIMEOUT)      contTimeout <= contTimeout + LARG_TIMEOUT'(1);
    end else begin
      contTimeout <= '0;
    end
  end

  assign pedidoScram = scram;
`else
  assign pedidoScram = 1'b0;
`endif

endmodule

// File: tb/tb_gerenciador_alarme_temperatura.sv
// Directed bench for the temperature alarm annunciator (DEBOUNCE=4, BLINK=8, TIMEOUT=20).
module tb_gerenciador_alarme_temperatura;

`ifdef ESCALONAMENTO_SCRAM_EN
  localparam logic SCRAM_ESPERADO = 1'b1;
`else
  localparam logic SCRAM_ESPERADO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       alarmeSonoroTemperatura;
  logic       botaoReconhecer;
  logic       sirene;
  logic       lampada;
  logic       pedidoScram;
  logic [1:0] estadoAlarme;

  int testes = 0;
  int falhas = 0;

  gerenciador_alarme_temperatura #(
    .DEBOUNCE_CICLOS(4),
    .PERIODO_PISCA  (8),
    .TIMEOUT_SCRAM  (20)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .alarmeSonoroTemperatura(alarmeSonoroTemperatura),
    .botaoReconhecer        (botaoReconhecer),
    .sirene                 (sirene),
    .lampada                (lampada),
    .pedidoScram            (pedidoScram),
    .estadoAlarme           (estadoAlarme)
  );

  always #5 clock = ~clock;

  task automatic ciclo(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic compara(input string tag, input logic [1:0] observado, input logic [1:0] esperado);
    testes++;
    assert (observado === esperado) else begin
      falhas++;
      $error("FAIL %s: observed %0d expected %0d", tag, observado, esperado);
    end
  endtask

  task automatic verifica(input string tag, input logic [1:0] est, input logic sir,
                          input logic lam, input logic scr);
    compara({tag, ".estado"}, estadoAlarme, est);
    compara({tag, ".sirene"}, {1'b0, sirene}, {1'b0, sir});
    compara({tag, ".lampada"}, {1'b0, lampada}, {1'b0, lam});
    compara({tag, ".scram"}, {1'b0, pedidoScram}, {1'b0, scr});
  endtask

  initial begin
    reset = 1'b1;
    alarmeSonoroTemperatura = 1'b0;
    botaoReconhecer = 1'b0;
    #2;
    verifica("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    ciclo(2);
    reset = 1'b0;
    ciclo(1);

    // Glitch of 3 samples must be absorbed
    alarmeSonoroTemperatura = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo(1);
      verifica("glitch_alto", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    alarmeSonoroTemperatura = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ciclo(1);
      verifica("glitch_baixo", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Trip on the 4th high sample, then blink at half-period 8
    alarmeSonoroTemperatura = 1'b1;
    ciclo(3);
    verifica("pre_disparo", 2'd0, 1'b0, 1'b0, 1'b0);
    ciclo(1);
    verifica("disparo", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(7);
    verifica("pisca_fim_fase1", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(1);
    verifica("pisca_fase0", 2'd1, 1'b0, 1'b0, 1'b0);
    ciclo(7);
    verifica("pisca_fim_fase0", 2'd1, 1'b0, 1'b0, 1'b0);
    ciclo(1);
    verifica("pisca_fase1b", 2'd1, 1'b1, 1'b1, 1'b0);

    // Acknowledge, hold the button, then clear
    botaoReconhecer = 1'b1;
    ciclo(1);
    verifica("reconhecido", 2'd2, 1'b0, 1'b1, 1'b0);
    ciclo(2);
    verifica("botao_mantido", 2'd2, 1'b0, 1'b1, 1'b0);
    botaoReconhecer = 1'b0;
    alarmeSonoroTemperatura = 1'b0;
    ciclo(3);
    verifica("pre_liberacao", 2'd2, 1'b0, 1'b1, 1'b0);
    ciclo(1);
    verifica("liberado", 2'd0, 1'b0, 1'b0, 1'b0);

    // Clear without acknowledge -> return unacknowledged, then acknowledge
    alarmeSonoroTemperatura = 1'b1;
    ciclo(4);
    verifica("disparo2", 2'd1, 1'b1, 1'b1, 1'b0);
    alarmeSonoroTemperatura = 1'b0;
    ciclo(3);
    verifica("pre_retorno", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(1);
    verifica("retorno", 2'd3, 1'b0, 1'b1, 1'b0);
    ciclo(8);
    verifica("retorno_pisca", 2'd3, 1'b0, 1'b0, 1'b0);
    botaoReconhecer = 1'b1;
    ciclo(1);
    verifica("retorno_reconhecido", 2'd0, 1'b0, 1'b0, 1'b0);
    botaoReconhecer = 1'b0;
    ciclo(1);

    // Re-trip from return state; trip beats a simultaneous acknowledge
    alarmeSonoroTemperatura = 1'b1;
    ciclo(4);
    alarmeSonoroTemperatura = 1'b0;
    ciclo(4);
    verifica("retorno2", 2'd3, 1'b0, 1'b1, 1'b0);
    alarmeSonoroTemperatura = 1'b1;
    ciclo(3);
    verifica("retorno2_espera", 2'd3, 1'b0, 1'b1, 1'b0);
    botaoReconhecer = 1'b1;
    ciclo(1);
    verifica("redisparo_vence", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(1);
    verifica("botao_segurado", 2'd1, 1'b1, 1'b1, 1'b0);
    botaoReconhecer = 1'b0;
    ciclo(1);

    // Acknowledge and clear on the same edge -> straight to NORMAL
    alarmeSonoroTemperatura = 1'b0;
    ciclo(3);
    verifica("pre_simultaneo", 2'd1, 1'b1, 1'b1, 1'b0);
    botaoReconhecer = 1'b1;
    ciclo(1);
    verifica("simultaneo", 2'd0, 1'b0, 1'b0, 1'b0);
    botaoReconhecer = 1'b0;
    ciclo(1);

    // SCRAM escalation after 20 cycles unacknowledged
    alarmeSonoroTemperatura = 1'b1;
    ciclo(4);
    verifica("disparo_scram", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(19);
    verifica("pre_scram", 2'd1, 1'b1, 1'b1, 1'b0);
    ciclo(1);
    verifica("scram", 2'd1, 1'b1, 1'b1, SCRAM_ESPERADO);
    botaoReconhecer = 1'b1;
    ciclo(1);
    verifica("scram_reconhecido", 2'd2, 1'b0, 1'b1, SCRAM_ESPERADO);
    botaoReconhecer = 1'b0;
    alarmeSonoroTemperatura = 1'b0;
    ciclo(4);
    verifica("scram_liberado", 2'd0, 1'b0, 1'b0, SCRAM_ESPERADO);

    // Asynchronous reset mid-alarm, then re-trip with raw held high
    alarmeSonoroTemperatura = 1'b1;
    ciclo(4);
    verifica("disparo_final", 2'd1, 1'b1, 1'b1, SCRAM_ESPERADO);
    #2;
    reset = 1'b1;
    #1;
    verifica("reset_assincrono", 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    ciclo(3);
    verifica("pos_reset_espera", 2'd0, 1'b0, 1'b0, 1'b0);
    ciclo(1);
    verifica("pos_reset_disparo", 2'd1, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
